// File: rtl/dp_pkg.sv
// Shared types for the bus datapath: bus source and ALU op encodings,
// register index width and the shift-amount width helper.
package dp_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT, ALU_NEG, ALU_SHL,
        ALU_SHR, ALU_SHRA, ALU_ROL, ALU_ROR, ALU_MUL, ALU_DIV
    } alu_op_t;

    typedef enum logic [3:0] {
        BUS_REG, BUS_HI, BUS_LO, BUS_ZHI, BUS_ZLO, BUS_PC, BUS_MDR,
        BUS_INPORT, BUS_CSE, BUS_NONE
    } bus_src_t;

    localparam int NUM_REGS_DEF = 16;
    localparam int IDX_W = $clog2(NUM_REGS_DEF);

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sh_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/dp_if.sv
// Control/observation bundle between the control unit (master) and the
// datapath (slave): bus selects, write enables, ALU op, memory/port data,
// bus/IR/MAR observation and the multiply/divide handshake.
interface dp_if
    import dp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = NUM_REGS_DEF
);
    localparam int IW = idx_w(NUM_REGS);

    bus_src_t          bus_src;
    logic [IW-1:0]     reg_out_sel;
    logic              reg_in_en;
    logic [IW-1:0]     reg_in_sel;
    logic              PCin, IRin, Yin, HIin, LOin, MARin, MDRin;
    logic              Read, Zin, IncPC;
    alu_op_t           alu_op;
    logic [DATA_W-1:0] Mdatain, InPort;
    logic [DATA_W-1:0] bus_out, ir_q, mar_q;
    logic              busy, done, div0;

    modport master (
        output bus_src, reg_out_sel, reg_in_en, reg_in_sel,
        output PCin, IRin, Yin, HIin, LOin, MARin, MDRin,
        output Read, Zin, IncPC, alu_op, Mdatain, InPort,
        input  bus_out, ir_q, mar_q, busy, done, div0
    );

    modport slave (
        input  bus_src, reg_out_sel, reg_in_en, reg_in_sel,
        input  PCin, IRin, Yin, HIin, LOin, MARin, MDRin,
        input  Read, Zin, IncPC, alu_op, Mdatain, InPort,
        output bus_out, ir_q, mar_q, busy, done, div0
    );

endinterface

// File: rtl/bus_datapath_muldiv.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes, then sign fix). Ports: start/is_div/op_a/op_b in;
// busy/done/div0 handshake and the z_we strobe with z_hi/z_lo out.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic              z_we,
    output logic [DATA_W-1:0] z_hi,
    output logic [DATA_W-1:0] z_lo
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              div_q, div0_q, neg_q, neg_r, q1_r, q1_n;
    logic [DATA_W:0]   hi_r, hi_n, sum, shl, diff;
    logic [DATA_W-1:0] lo_r, lo_n, m_r, a_r, rem_m;

    // One Booth or restoring step; hi carries an extra bit so that
    // subtracting the most-negative multiplicand cannot overflow.
    always_comb begin
        sum  = hi_r;
        shl  = {hi_r[DATA_W-1:0], lo_r[DATA_W-1]};
        diff = shl - {1'b0, m_r};
        q1_n = q1_r;
        if (div_q) begin
            if (!diff[DATA_W]) begin
                hi_n = diff;
                lo_n = {lo_r[DATA_W-2:0], 1'b1};
            end else begin
                hi_n = shl;
                lo_n = {lo_r[DATA_W-2:0], 1'b0};
            end
        end else begin
            unique case ({lo_r[0], q1_r})
                2'b01:   sum = hi_r + {m_r[DATA_W-1], m_r};
                2'b10:   sum = hi_r - {m_r[DATA_W-1], m_r};
                default: sum = hi_r;
            endcase
            hi_n = {sum[DATA_W], sum[DATA_W:1]};
            lo_n = {sum[0], lo_r[DATA_W-1:1]};
            q1_n = lo_r[0];
        end
    end

    always_comb begin
        rem_m = hi_n[DATA_W-1:0];
        if (!div_q) begin
            z_hi = hi_n[DATA_W-1:0];
            z_lo = lo_n;
        end else if (m_r == '0) begin
            z_hi = a_r;
            z_lo = '1;
        end else begin
            z_hi = neg_r ? -rem_m : rem_m;
            z_lo = neg_q ? -lo_n : lo_n;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= S_IDLE;
            cnt    <= '0;
            div_q  <= 1'b0;
            div0_q <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            q1_r   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            m_r    <= '0;
            a_r    <= '0;
        end else if (start && state != S_RUN) begin
            state  <= S_RUN;
            cnt    <= CNT_MAX;
            div_q  <= is_div;
            div0_q <= 1'b0;
            q1_r   <= 1'b0;
            hi_r   <= '0;
            a_r    <= op_a;
            if (is_div) begin
                lo_r  <= op_a[DATA_W-1] ? -op_a : op_a;
                m_r   <= op_b[DATA_W-1] ? -op_b : op_b;
                neg_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                neg_r <= op_a[DATA_W-1];
            end else begin
                lo_r  <= op_b;
                m_r   <= op_a;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end
        end else if (state == S_RUN) begin
            hi_r <= hi_n;
            lo_r <= lo_n;
            q1_r <= q1_n;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
                state  <= S_DONE;
                div0_q <= div_q && (m_r == '0);
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign div0 = done && div0_q;
    assign z_we = busy && (cnt == '0);

endmodule

// File: rtl/bus_datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux and
// single-cycle ALU. Ports: clk, clr (sync, active high), d (dp_if.slave).
module bus_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int CONST_W  = 19
) (
    input logic clk,
    input logic clr,
    dp_if.slave d
);
    localparam int SW = sh_w(DATA_W);
    localparam logic [SW:0] DW_L = DATA_W[SW:0];
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] gpr [NUM_REGS];
    logic [DATA_W-1:0] pc, ir, y, z_hi, z_lo, hi, lo, mar, mdr;
    logic [DATA_W-1:0] bus, alu_res, cse, md_hi, md_lo;
    logic [SW-1:0]     sh;
    logic [SW:0]       rsh;
    logic              is_md, md_start, alu_we, busy, md_we;

    assign cse = {{(DATA_W-CONST_W){ir[CONST_W-1]}}, ir[CONST_W-1:0]};

    always_comb begin
        case (d.bus_src)
            BUS_REG:    bus = gpr[d.reg_out_sel];
            BUS_HI:     bus = hi;
            BUS_LO:     bus = lo;
            BUS_ZHI:    bus = z_hi;
            BUS_ZLO:    bus = z_lo;
            BUS_PC:     bus = pc;
            BUS_MDR:    bus = mdr;
            BUS_INPORT: bus = d.InPort;
            BUS_CSE:    bus = cse;
            default:    bus = '0;
        endcase
    end

    // Rotates combine the two shifts; a zero amount leaves y unchanged
    // because the complementary shift by DATA_W yields zero.
    assign sh  = bus[SW-1:0];
    assign rsh = DW_L - {1'b0, sh};

    always_comb begin
        case (d.alu_op)
            ALU_ADD:  alu_res = y + bus;
            ALU_SUB:  alu_res = y - bus;
            ALU_AND:  alu_res = y & bus;
            ALU_OR:   alu_res = y | bus;
            ALU_NOT:  alu_res = ~bus;
            ALU_NEG:  alu_res = -bus;
            ALU_SHL:  alu_res = y << sh;
            ALU_SHR:  alu_res = y >> sh;
            ALU_SHRA: alu_res = $signed(y) >>> sh;
            ALU_ROL:  alu_res = (y << sh) | (y >> rsh);
            ALU_ROR:  alu_res = (y >> sh) | (y << rsh);
            default:  alu_res = '0;
        endcase
    end

    assign is_md    = !d.IncPC &&
                      (d.alu_op == ALU_MUL || d.alu_op == ALU_DIV);
    assign md_start = d.Zin && is_md && !busy;
    assign alu_we   = d.Zin && !is_md && !busy;

    muldiv_unit #(.DATA_W(DATA_W)) u_md (
        .clk    (clk),
        .clr    (clr),
        .start  (md_start),
        .is_div (d.alu_op == ALU_DIV),
        .op_a   (y),
        .op_b   (bus),
        .busy   (busy),
        .done   (d.done),
        .div0   (d.div0),
        .z_we   (md_we),
        .z_hi   (md_hi),
        .z_lo   (md_lo)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
            pc   <= '0;
            ir   <= '0;
            y    <= '0;
            z_hi <= '0;
            z_lo <= '0;
            hi   <= '0;
            lo   <= '0;
            mar  <= '0;
            mdr  <= '0;
        end else begin
            if (d.reg_in_en) gpr[d.reg_in_sel] <= bus;
            if (d.PCin)  pc  <= bus;
            if (d.IRin)  ir  <= bus;
            if (d.Yin)   y   <= bus;
            if (d.HIin)  hi  <= bus;
            if (d.LOin)  lo  <= bus;
            if (d.MARin) mar <= bus;
            if (d.MDRin) mdr <= d.Read ? d.Mdatain : bus;
            if (md_we) begin
                z_hi <= md_hi;
                z_lo <= md_lo;
            end else if (alu_we) begin
                z_hi <= '0;
                z_lo <= d.IncPC ? bus + ONE : alu_res;
            end
        end
    end

    assign d.bus_out = bus;
    assign d.ir_q    = ir;
    assign d.mar_q   = mar;
    assign d.busy    = busy;

endmodule

// File: tb/tb_bus_datapath.sv
// Bench for bus_datapath: a 32-bit instance checked every cycle against a
// behavioural model plus literal checks, and a 16-bit instance for width.
module tb_bus_datapath;
    import dp_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    dp_if #(.DATA_W(32), .NUM_REGS(16)) d32 ();
    dp_if #(.DATA_W(16), .NUM_REGS(8))  d16 ();

    bus_datapath #(.DATA_W(32), .NUM_REGS(16), .CONST_W(19)) dut (
        .clk (clk), .clr (clr), .d (d32)
    );
    bus_datapath #(.DATA_W(16), .NUM_REGS(8), .CONST_W(11)) dut16 (
        .clk (clk), .clr (clr), .d (d16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the 32-bit instance
    logic [31:0] m_gpr [16];
    logic [31:0] m_pc, m_ir, m_y, m_zhi, m_zlo, m_hi, m_lo, m_mar, m_mdr;
    logic [31:0] p_hi, p_lo;
    logic        m_done, m_div0, p_div0;
    int          m_left;

    function automatic logic [31:0] m_bus();
        case (d32.bus_src)
            BUS_REG:    return m_gpr[d32.reg_out_sel];
            BUS_HI:     return m_hi;
            BUS_LO:     return m_lo;
            BUS_ZHI:    return m_zhi;
            BUS_ZLO:    return m_zlo;
            BUS_PC:     return m_pc;
            BUS_MDR:    return m_mdr;
            BUS_INPORT: return d32.InPort;
            BUS_CSE:    return m_ir[18] ? (m_ir | 32'hFFF8_0000)
                                        : (m_ir & 32'h0007_FFFF);
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input alu_op_t op,
                                          input logic [31:0] a, b);
        int s;
        s = int'(b[4:0]);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_NOT:  return ~b;
            ALU_NEG:  return 32'h0 - b;
            ALU_SHL:  return a << s;
            ALU_SHR:  return a >> s;
            ALU_SHRA: return $signed(a) >>> s;
            ALU_ROL:  return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            ALU_ROR:  return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            default:  return 32'h0;
        endcase
    endfunction

    task automatic m_muldiv(input alu_op_t op, input logic [31:0] a, b);
        int sa, sb, q, r;
        longint p;
        sa = a;
        sb = b;
        p_div0 = 1'b0;
        if (op == ALU_MUL) begin
            p = longint'(sa) * longint'(sb);
            p_hi = p[63:32];
            p_lo = p[31:0];
        end else if (sb == 0) begin
            p_lo = 32'hFFFF_FFFF;
            p_hi = a;
            p_div0 = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            p_lo = a;
            p_hi = 32'h0;
        end else begin
            q = sa / sb;
            r = sa % sb;
            p_lo = q;
            p_hi = r;
        end
    endtask

    initial forever begin
        logic [31:0] b;
        @(posedge clk);
        b = m_bus();
        if (clr) begin
            for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
            {m_pc, m_ir, m_y, m_zhi, m_zlo} = '0;
            {m_hi, m_lo, m_mar, m_mdr} = '0;
            m_left = 0;
            m_done = 1'b0;
            m_div0 = 1'b0;
        end else begin
            m_done = 1'b0;
            m_div0 = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_zhi  = p_hi;
                    m_zlo  = p_lo;
                    m_done = 1'b1;
                    m_div0 = p_div0;
                end
            end else if (d32.Zin) begin
                if (d32.IncPC) begin
                    m_zlo = b + 32'h1;
                    m_zhi = 32'h0;
                end else if (d32.alu_op == ALU_MUL || d32.alu_op == ALU_DIV) begin
                    m_muldiv(d32.alu_op, m_y, b);
                    m_left = 32;
                end else begin
                    m_zlo = m_alu(d32.alu_op, m_y, b);
                    m_zhi = 32'h0;
                end
            end
            if (d32.reg_in_en) m_gpr[d32.reg_in_sel] = b;
            if (d32.PCin)  m_pc  = b;
            if (d32.IRin)  m_ir  = b;
            if (d32.Yin)   m_y   = b;
            if (d32.HIin)  m_hi  = b;
            if (d32.LOin)  m_lo  = b;
            if (d32.MARin) m_mar = b;
            if (d32.MDRin) m_mdr = d32.Read ? d32.Mdatain : b;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_bus",  d32.bus_out, m_bus());
            chk("cyc_ir",   d32.ir_q, m_ir);
            chk("cyc_mar",  d32.mar_q, m_mar);
            chk("cyc_busy", {31'h0, d32.busy}, {31'h0, m_left > 0});
            chk("cyc_done", {31'h0, d32.done}, {31'h0, m_done});
            chk("cyc_div0", {31'h0, d32.div0}, {31'h0, m_div0});
        end
    end

    task automatic idle();
        d32.bus_src = BUS_NONE; d32.reg_out_sel = '0;
        d32.reg_in_en = 0; d32.reg_in_sel = '0;
        {d32.PCin, d32.IRin, d32.Yin, d32.HIin, d32.LOin} = '0;
        {d32.MARin, d32.MDRin, d32.Read, d32.Zin, d32.IncPC} = '0;
        d32.alu_op = ALU_ADD; d32.Mdatain = '0; d32.InPort = '0;
        d16.bus_src = BUS_NONE; d16.reg_out_sel = '0;
        d16.reg_in_en = 0; d16.reg_in_sel = '0;
        {d16.PCin, d16.IRin, d16.Yin, d16.HIin, d16.LOin} = '0;
        {d16.MARin, d16.MDRin, d16.Read, d16.Zin, d16.IncPC} = '0;
        d16.alu_op = ALU_ADD; d16.Mdatain = '0; d16.InPort = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic put_y(input logic [31:0] v);
        d32.bus_src = BUS_INPORT; d32.InPort = v; d32.Yin = 1; cyc();
    endtask

    task automatic alu1(input logic [31:0] b, input alu_op_t op);
        d32.bus_src = BUS_INPORT; d32.InPort = b;
        d32.alu_op = op; d32.Zin = 1; cyc();
    endtask

    task automatic zchk(input string nm, input logic [31:0] h, l);
        d32.bus_src = BUS_ZLO; #1 chk({nm, "_zlo"}, d32.bus_out, l);
        d32.bus_src = BUS_ZHI; #1 chk({nm, "_zhi"}, d32.bus_out, h);
    endtask

    task automatic wait_busy(input int n0, output int n);
        n = n0;
        while (d32.busy && n < 100) begin
            d32.bus_src = BUS_ZLO;
            n++;
            cyc();
        end
    endtask

    task automatic run_md(input string nm, input logic [31:0] a, b,
                          input alu_op_t op, input logic [31:0] eh, el,
                          input logic dz);
        int n;
        put_y(a);
        alu1(b, op);
        wait_busy(0, n);
        chk({nm, "_busy_cycles"}, n, 32);
        chk({nm, "_done"}, {31'h0, d32.done}, 32'h1);
        chk({nm, "_div0"}, {31'h0, d32.div0}, {31'h0, dz});
        zchk(nm, eh, el);
        cyc();
        chk({nm, "_done_one_cycle"}, {31'h0, d32.done}, 32'h0);
    endtask

    initial begin
        int n, nd;
        idle();
        cyc();
        clr = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            d32.bus_src = BUS_REG; d32.reg_out_sel = 4'(i);
            #1 chk("reset_reg", d32.bus_out, 32'h0);
            cyc();
        end
        chk("reset_busy", {31'h0, d32.busy}, 32'h0);
        chk("reset_ir", d32.ir_q, 32'h0);

        d32.Mdatain = 32'h34; d32.Read = 1; d32.MDRin = 1; cyc();
        d32.bus_src = BUS_MDR; d32.reg_in_en = 1; d32.reg_in_sel = 4'd2; cyc();
        d32.Mdatain = 32'h45; d32.Read = 1; d32.MDRin = 1; cyc();
        d32.bus_src = BUS_MDR; d32.reg_in_en = 1; d32.reg_in_sel = 4'd3; cyc();
        d32.bus_src = BUS_REG; d32.reg_out_sel = 4'd2; d32.Yin = 1; cyc();
        d32.bus_src = BUS_REG; d32.reg_out_sel = 4'd3;
        d32.alu_op = ALU_AND; d32.Zin = 1; cyc();
        zchk("and", 32'h0, 32'h4);
        d32.bus_src = BUS_ZLO; d32.reg_in_en = 1; d32.reg_in_sel = 4'd1; cyc();
        d32.bus_src = BUS_REG; d32.reg_out_sel = 4'd1;
        #1 chk("r1_and", d32.bus_out, 32'h4);
        cyc();

        d32.bus_src = BUS_INPORT; d32.InPort = 32'h0004_0001; d32.IRin = 1; cyc();
        d32.bus_src = BUS_CSE;
        #1 chk("cse", d32.bus_out, 32'hFFFC_0001);
        chk("ir_q", d32.ir_q, 32'h0004_0001);
        d32.bus_src = BUS_INPORT; d32.InPort = 32'h123; d32.MARin = 1; cyc();
        chk("mar_q", d32.mar_q, 32'h123);
        d32.bus_src = BUS_INPORT; d32.InPort = 32'h100; d32.PCin = 1; cyc();
        d32.bus_src = BUS_PC; d32.IncPC = 1; d32.Zin = 1;
        d32.alu_op = ALU_SUB; cyc();
        zchk("incpc", 32'h0, 32'h101);
        put_y(32'd10);
        alu1(32'd3, ALU_SUB);
        zchk("sub", 32'h0, 32'h7);

        run_md("mul", 32'hFFFF_FFFA, 32'd7, ALU_MUL,
               32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        run_md("div", 32'hFFFF_FFF9, 32'd2, ALU_DIV,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_md("div0", 32'd9, 32'd0, ALU_DIV, 32'd9, 32'hFFFF_FFFF, 1'b1);
        run_md("divmin", 32'h8000_0000, 32'hFFFF_FFFF, ALU_DIV,
               32'h0, 32'h8000_0000, 1'b0);

        put_y(32'd3);
        alu1(32'd5, ALU_MUL);
        cyc(); cyc(); cyc(); cyc();
        alu1(32'd9, ALU_MUL);
        alu1(32'd9, ALU_ADD);
        wait_busy(6, n);
        chk("ignore_busy_cycles", n, 32);
        chk("ignore_done", {31'h0, d32.done}, 32'h1);
        zchk("ignore", 32'h0, 32'd15);
        cyc();

        put_y(32'd100);
        alu1(32'd200, ALU_MUL);
        for (int i = 0; i < 9; i++) cyc();
        chk("abort_busy_before", {31'h0, d32.busy}, 32'h1);
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("abort_busy", {31'h0, d32.busy}, 32'h0);
        zchk("abort", 32'h0, 32'h0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (d32.done) nd++;
            cyc();
        end
        chk("abort_no_done", nd, 0);

        d16.bus_src = BUS_INPORT; d16.InPort = 16'h8001; d16.Yin = 1; cyc();
        d16.bus_src = BUS_INPORT; d16.InPort = 16'd1;
        d16.alu_op = ALU_ROL; d16.Zin = 1; cyc();
        d16.bus_src = BUS_ZLO;
        #1 chk("rol16", {16'h0, d16.bus_out}, 32'h0003);
        cyc();
        d16.bus_src = BUS_INPORT; d16.InPort = 16'h8000; d16.Yin = 1; cyc();
        d16.bus_src = BUS_INPORT; d16.InPort = 16'd3;
        d16.alu_op = ALU_SHRA; d16.Zin = 1; cyc();
        d16.bus_src = BUS_ZLO;
        #1 chk("shra16", {16'h0, d16.bus_out}, 32'hF000);
        cyc();
        d16.bus_src = BUS_INPORT; d16.InPort = 16'h0100; d16.Yin = 1; cyc();
        d16.bus_src = BUS_INPORT; d16.InPort = 16'h0100;
        d16.alu_op = ALU_MUL; d16.Zin = 1; cyc();
        n = 0;
        while (d16.busy && n < 100) begin
            n++;
            cyc();
        end
        chk("mul16_busy_cycles", n, 16);
        chk("mul16_done", {31'h0, d16.done}, 32'h1);
        d16.bus_src = BUS_ZHI;
        #1 chk("mul16_zhi", {16'h0, d16.bus_out}, 32'h0001);
        d16.bus_src = BUS_ZLO;
        #1 chk("mul16_zlo", {16'h0, d16.bus_out}, 32'h0000);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_datapath.md
# bus_datapath

Parametrised successor to the single-bus CPU datapath. Holds NUM_REGS general registers plus PC, IR, Y, Z_HI/Z_LO, HI, LO, MAR and MDR around one shared bus. Adds encoded bus-source and destination selects, a full single-cycle ALU, and a sequential signed multiply/divide unit with a busy/done handshake. The control unit drives it one micro-step per clock.

## Interface
- DATA_W, 32: width of the bus and of every register.
- NUM_REGS, 16: number of general registers; power of two, 2..32.
- CONST_W, 19: IR low field sign-extended onto the bus for BUS_CSE.
- clk  in  1  single clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- bus_src  in  4  bus_src_t: REG, HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSE, NONE.
- reg_out_sel  in  log2(NUM_REGS)  register driven when bus_src=REG.
- reg_in_en, reg_in_sel  in  1, log2(NUM_REGS)  write bus into the selected register.
- PCin, IRin, Yin, HIin, LOin, MARin, MDRin  in  1 each  write enables.
- Read  in  1  MDR source: 1 = Mdatain, 0 = bus.
- Zin  in  1  capture ALU result, or start MUL/DIV.
- IncPC  in  1  with Zin, Z_LO <= bus + 1, overriding alu_op.
- alu_op  in  4  alu_op_t: ADD, SUB, AND, OR, NOT, NEG, SHL, SHR, SHRA, ROL, ROR, MUL, DIV.
- Mdatain, InPort  in  DATA_W  memory data and input port.
- bus_out, ir_q, mar_q  out  DATA_W  observability and the memory address.
- busy, done, div0  out  1  multiply/divide handshake.

## Operation
- Bus is a combinational mux of bus_src. NONE drives 0. CSE drives sign-extended IR[CONST_W-1:0].
- Operand A is always Y; operand B is always the bus. SUB = Y - bus. NOT and NEG act on the bus. Shift amount = bus[log2(DATA_W)-1:0]. SHRA is arithmetic.
- Single-cycle ops: Zin loads Z_LO with the result and Z_HI with 0. All arithmetic wraps modulo 2^DATA_W.
- MUL: signed Y*bus. Z_HI:Z_LO receives the 2*DATA_W-bit product. Radix-2 Booth, one step per cycle.
- DIV: signed Y/bus. Z_LO = quotient, truncated toward zero. Z_HI = remainder, with the sign of the dividend. Restoring algorithm on magnitudes, then sign fix.
- Divide by zero: Z_LO = all ones, Z_HI = dividend, div0 = 1 together with done.
- Most-negative / -1: quotient wraps to the most-negative value, remainder = 0.
- Muldiv FSM states: IDLE; RUN (counter DATA_W-1 down to 0); DONE, which lasts one cycle.
  - IDLE -> RUN on Zin with MUL or DIV. Operands are latched at that edge.
  - RUN -> DONE when the counter reaches 0.
  - DONE -> IDLE.
- Zin while busy is ignored: no restart, no Z write.
- Non-Z registers and the bus stay fully usable while busy. Reading Z during RUN returns the old Z.
- Reset values: all registers, bus_out, busy, done and div0 are 0. The FSM resets to IDLE.

## Timing
- Every register write lands on the rising edge where its enable is high and takes the bus value of that cycle. The new value is visible the next cycle.
- Write and read of the same register in one cycle: the bus shows the old value.
- Single-cycle ALU: Zin at cycle t gives Z valid at t+1.
- MUL/DIV started at cycle t:
  - busy = 1 during t+1 .. t+DATA_W.
  - Z written at the edge that ends t+DATA_W.
  - done (and div0, if applicable) = 1 for exactly cycle t+DATA_W+1, when busy is already 0.
- A new Zin is accepted at t+DATA_W+1.
- clr during RUN or DONE: at the next edge FSM = IDLE, busy/done/div0 = 0, Z = 0. No late Z write follows.

## Structure
- Package dp_pkg holds: alu_op_t and bus_src_t enums, localparam IDX_W = $clog2(NUM_REGS), and the shift-width helper.
- Sub-module muldiv_unit holds the FSM, counter, Booth and restoring datapaths, sign correction, busy/done/div0 outputs and the Z write strobe.
- The register array, bus mux and single-cycle ALU stay in the top module.

## Test plan
- Reset: clr for 1 cycle, then bus_src=REG for each index -> bus_out = 0. busy = 0.
- Load and AND:
  - Mdatain=0x34 with Read+MDRin, then MDR->R2. Likewise 0x45 -> R3.
  - Y<=R2, then bus=R3 with AND+Zin -> Z_LO = 0x00000004, Z_HI = 0.
  - ZLO->R1 -> R1 = 4.
- MUL: Y = 0xFFFFFFFA (-6), bus = 7, Zin -> busy for 32 cycles. Then Z_HI = 0xFFFFFFFF, Z_LO = 0xFFFFFFD6, done one-cycle pulse.
- DIV:
  - Y = -7, bus = 2 -> Z_LO = 0xFFFFFFFD, Z_HI = 0xFFFFFFFF, div0 = 0.
  - Y = 9, bus = 0 -> Z_LO = 0xFFFFFFFF, Z_HI = 9, div0 = 1 with done.
- Abort and ignore:
  - Second Zin at busy cycle 5 -> no effect; done still arrives at cycle 33.
  - clr at busy cycle 10 of a MUL -> busy = 0 next cycle, Z = 0, no done pulse ever.
- DATA_W=16, NUM_REGS=8:
  - ROL 0x8001 by 1 -> 0x0003.
  - SHRA 0x8000 by 3 -> 0xF000.
  - MUL 0x0100*0x0100 -> Z_HI = 0x0001, Z_LO = 0x0000, busy for 16 cycles.
